// File: rtl/fc_rx_credit_scheduler_pkg.sv
// Shared types and default sizing for the receive-side flow-control credit scheduler.
package fc_pkg;

  typedef enum logic [1:0] {
    MWR = 2'd0,
    MRD = 2'd1,
    CPL = 2'd2
  } fc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } fc_state_e;

  localparam int FC_NUM_TYPES  = 3;
  localparam int FC_HDR_W      = 8;
  localparam int FC_DATA_W     = 12;
  localparam int FC_UPD_PERIOD = 256;
  localparam int FC_HDR_THR    = 4;

  // A single credit type still needs a one-bit type field.
  function automatic int type_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_rx_credit_scheduler_if.sv
// FC DLLP request channel between the credit scheduler and the DLLP transmitter.
interface fc_dllp_if
  import fc_pkg::*;
#(
  parameter int NUM_TYPES = FC_NUM_TYPES,
  parameter int HDR_W     = FC_HDR_W,
  parameter int DATA_W    = FC_DATA_W
);
  localparam int TYPE_W = type_w(NUM_TYPES);

  // A request transfers on a cycle where dllp_valid_o and dllp_ready_i are both 1;
  // while valid is high and ready is low every other field of the request holds stable.
  logic              dllp_valid_o;
  logic              dllp_ready_i;
  logic              dllp_initfc_o;
  logic              dllp_updatefc_o;
  logic [TYPE_W-1:0] dllp_type_o;
  logic [HDR_W-1:0]  hdr_credit_o;
  logic [DATA_W-1:0] data_credit_o;

  modport master (
    output dllp_valid_o, dllp_initfc_o, dllp_updatefc_o, dllp_type_o,
           hdr_credit_o, data_credit_o,
    input  dllp_ready_i
  );

  modport slave (
    input  dllp_valid_o, dllp_initfc_o, dllp_updatefc_o, dllp_type_o,
           hdr_credit_o, data_credit_o,
    output dllp_ready_i
  );
endinterface

// File: rtl/fc_rx_credit_scheduler_arb.sv
// Rotating-priority arbiter: searches requesters starting just after the last one served.
module fc_rr_arbiter
  import fc_pkg::*;
#(
  parameter int N = FC_NUM_TYPES
) (
  input  logic [N-1:0]           req,
  input  logic [type_w(N)-1:0]   last,
  output logic [N-1:0]           grant
);
  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fc_rx_credit_scheduler.sv
// Receive-side credit scheduler: advertises InitFC per type at link-up, then UpdateFC on timer or threshold.
module fc_rx_credit_scheduler
  import fc_pkg::*;
#(
  parameter int NUM_TYPES  = FC_NUM_TYPES,
  parameter int HDR_W      = FC_HDR_W,
  parameter int DATA_W     = FC_DATA_W,
  parameter int UPD_PERIOD = FC_UPD_PERIOD,
  parameter int HDR_THR    = FC_HDR_THR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        link_up_i,
  input  logic [NUM_TYPES*HDR_W-1:0]  buf_hdr_cap_i,
  input  logic [NUM_TYPES*DATA_W-1:0] buf_data_cap_i,
  input  logic [NUM_TYPES-1:0]        rel_valid_i,
  input  logic [NUM_TYPES*HDR_W-1:0]  rel_hdr_i,
  input  logic [NUM_TYPES*DATA_W-1:0] rel_data_i,
  fc_dllp_if.master                   dllp,
  output logic                        init_done_o,
  output fc_state_e                   dbg_state_o
);
  localparam int TYPE_W = type_w(NUM_TYPES);
  localparam int TMR_W  = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam logic [HDR_W-1:0] THR = HDR_W'(HDR_THR);

  fc_state_e         state;
  logic [HDR_W-1:0]  alloc_hdr  [NUM_TYPES];
  logic [DATA_W-1:0] alloc_data [NUM_TYPES];
  logic [HDR_W-1:0]  hdr_acc    [NUM_TYPES];
  logic [NUM_TYPES-1:0] pending, due, inf_hdr, inf_data;
  logic [TMR_W-1:0]  timer;
  logic [TYPE_W-1:0] last_served, init_idx;

  logic              valid_q, initfc_q, updatefc_q;
  logic [TYPE_W-1:0] type_q;
  logic [HDR_W-1:0]  hdr_q;
  logic [DATA_W-1:0] data_q;

  logic              accept, wrap;
  logic [NUM_TYPES-1:0] set_rel, clr, pending_n, due_n, req, grant;
  logic [HDR_W-1:0]  rel_h [NUM_TYPES];
  logic [DATA_W-1:0] rel_d [NUM_TYPES];
  logic [HDR_W-1:0]  acc_n [NUM_TYPES];
  logic [HDR_W:0]    acc_sum;
  logic [TYPE_W-1:0] grant_idx;
  logic [HDR_W-1:0]  sel_hdr, init_hdr;
  logic [DATA_W-1:0] sel_data, init_data;

  // A release landing on the acceptance cycle of its own type restarts that type's bookkeeping.
  always_comb begin
    accept    = valid_q && dllp.dllp_ready_i;
    wrap      = (state == ST_ACTIVE) && (timer == TMR_W'(UPD_PERIOD - 1));
    set_rel   = '0;
    clr       = '0;
    pending_n = pending;
    due_n     = due;
    acc_sum   = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      rel_h[t]   = rel_hdr_i[t*HDR_W +: HDR_W];
      rel_d[t]   = rel_data_i[t*DATA_W +: DATA_W];
      set_rel[t] = (state == ST_ACTIVE) && rel_valid_i[t] && !(inf_hdr[t] && inf_data[t]);
      clr[t]     = accept && updatefc_q && (type_q == TYPE_W'(t));
      acc_sum    = {1'b0, hdr_acc[t]} + {1'b0, rel_h[t]};
      if (clr[t]) begin
        pending_n[t] = set_rel[t];
        acc_n[t]     = set_rel[t] ? rel_h[t] : '0;
      end else begin
        pending_n[t] = pending[t] || set_rel[t];
        acc_n[t]     = set_rel[t] ? (acc_sum[HDR_W] ? '1 : acc_sum[HDR_W-1:0]) : hdr_acc[t];
      end
      due_n[t] = (due[t] && !clr[t]) || (wrap && pending_n[t]) ||
                 (pending_n[t] && (acc_n[t] >= THR));
    end
  end

  assign req = ((state == ST_ACTIVE) && !valid_q) ? due : '0;

  fc_rr_arbiter #(.N(NUM_TYPES)) u_arb (
    .req   (req),
    .last  (last_served),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_hdr   = '0;
    sel_data  = '0;
    init_hdr  = '0;
    init_data = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (grant[t]) begin
        grant_idx = TYPE_W'(t);
        sel_hdr   = alloc_hdr[t];
        sel_data  = alloc_data[t];
      end
      if (init_idx == TYPE_W'(t)) begin
        init_hdr  = alloc_hdr[t];
        init_data = alloc_data[t];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !link_up_i) begin
      state       <= ST_IDLE;
      pending     <= '0;
      due         <= '0;
      timer       <= '0;
      init_idx    <= '0;
      valid_q     <= 1'b0;
      initfc_q    <= 1'b0;
      updatefc_q  <= 1'b0;
      type_q      <= '0;
      hdr_q       <= '0;
      data_q      <= '0;
      last_served <= '0;
      inf_hdr     <= '0;
      inf_data    <= '0;
      for (int t = 0; t < NUM_TYPES; t++) begin
        alloc_hdr[t]  <= '0;
        alloc_data[t] <= '0;
        hdr_acc[t]    <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_INIT;
          init_idx <= '0;
          for (int t = 0; t < NUM_TYPES; t++) begin
            alloc_hdr[t]  <= buf_hdr_cap_i[t*HDR_W +: HDR_W];
            alloc_data[t] <= buf_data_cap_i[t*DATA_W +: DATA_W];
            inf_hdr[t]    <= (buf_hdr_cap_i[t*HDR_W +: HDR_W] == '0);
            inf_data[t]   <= (buf_data_cap_i[t*DATA_W +: DATA_W] == '0);
          end
        end
        ST_INIT: begin
          if (!valid_q) begin
            valid_q    <= 1'b1;
            initfc_q   <= 1'b1;
            updatefc_q <= 1'b0;
            type_q     <= init_idx;
            hdr_q      <= init_hdr;
            data_q     <= init_data;
          end else if (accept) begin
            valid_q  <= 1'b0;
            initfc_q <= 1'b0;
            if (init_idx == TYPE_W'(NUM_TYPES - 1)) begin
              state <= ST_ACTIVE;
              timer <= '0;
            end else begin
              init_idx <= init_idx + TYPE_W'(1);
            end
          end
        end
        ST_ACTIVE: begin
          timer   <= wrap ? '0 : timer + TMR_W'(1);
          pending <= pending_n;
          due     <= due_n;
          for (int t = 0; t < NUM_TYPES; t++) begin
            hdr_acc[t] <= acc_n[t];
            if (set_rel[t] && !inf_hdr[t])  alloc_hdr[t]  <= alloc_hdr[t] + rel_h[t];
            if (set_rel[t] && !inf_data[t]) alloc_data[t] <= alloc_data[t] + rel_d[t];
          end
          if (accept) begin
            valid_q     <= 1'b0;
            updatefc_q  <= 1'b0;
            last_served <= type_q;
          end else if (!valid_q && (|due)) begin
            valid_q    <= 1'b1;
            initfc_q   <= 1'b0;
            updatefc_q <= 1'b1;
            type_q     <= grant_idx;
            hdr_q      <= sel_hdr;
            data_q     <= sel_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dllp.dllp_valid_o    = valid_q;
  assign dllp.dllp_initfc_o   = initfc_q;
  assign dllp.dllp_updatefc_o = updatefc_q;
  assign dllp.dllp_type_o     = type_q;
  assign dllp.hdr_credit_o    = hdr_q;
  assign dllp.data_credit_o   = data_q;
  assign init_done_o          = (state == ST_ACTIVE);
  assign dbg_state_o          = state;
endmodule

// File: doc/fc_rx_credit_scheduler.md
FC_RX_CREDIT_SCHEDULER -- requirements
Module: fc_rx_credit_scheduler

Interface
REQ-001 SHALL have parameter NUM_TYPES, default 3, number of credit types (0 MWr/posted, 1 MRd/non-posted, 2 Cpl).
REQ-002 SHALL have parameter HDR_W, default 8, header credit width.
REQ-003 SHALL have parameter DATA_W, default 12, data credit width.
REQ-004 SHALL have parameter UPD_PERIOD, default 256, UpdateFC timer period in cycles (>=2).
REQ-005 SHALL have parameter HDR_THR, default 4, released-header count that forces an UpdateFC before timer expiry.
REQ-006 SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 link_up_i  input  1  data link layer up; low forces return to IDLE.
REQ-009 buf_hdr_cap_i  input  NUM_TYPES*HDR_W  per-type header buffer capacity; 0 = infinite.
REQ-010 buf_data_cap_i  input  NUM_TYPES*DATA_W  per-type data buffer capacity; 0 = infinite.
REQ-011 rel_valid_i  input  NUM_TYPES  per-type credit-release strobe from the RX buffer.
REQ-012 rel_hdr_i  input  NUM_TYPES*HDR_W  headers released this cycle, per type.
REQ-013 rel_data_i  input  NUM_TYPES*DATA_W  data credits released this cycle, per type.
REQ-014 dllp_valid_o  output  1  FC DLLP request valid.
REQ-015 dllp_ready_i  input  1  DLLP transmitter accepts the request.
REQ-016 dllp_initfc_o / dllp_updatefc_o  output  1 each  DLLP kind, one-hot while valid.
REQ-017 dllp_type_o  output  $clog2(NUM_TYPES)  credit type of the DLLP.
REQ-018 hdr_credit_o / data_credit_o  output  HDR_W / DATA_W  advertised CREDITS_ALLOCATED values.
REQ-019 init_done_o  output  1  high in ACTIVE state.

Function
REQ-020 SHALL implement FSM IDLE -> INIT -> ACTIVE; IDLE -> INIT when link_up_i=1; INIT -> ACTIVE after the InitFC of the last type is accepted; any state -> IDLE when link_up_i=0.
REQ-021 On entering INIT, SHALL load per-type alloc_hdr/alloc_data counters from buf_hdr_cap_i/buf_data_cap_i.
REQ-022 In INIT, SHALL issue one InitFC per type in ascending type order, carrying the loaded counter values; infinite fields advertised as 0.
REQ-023 Handshake: transfer occurs on a cycle with dllp_valid_o=1 and dllp_ready_i=1; while valid=1 and ready=0, all dllp_* and credit outputs SHALL hold stable.
REQ-024 In ACTIVE, rel_valid_i[t] SHALL add rel_hdr_i/rel_data_i to alloc counters modulo 2^HDR_W / 2^DATA_W (wrap-around is legal), set pending[t], and add to hdr_acc[t] (saturating).
REQ-025 Releases in IDLE/INIT SHALL be ignored.
REQ-026 A free-running timer SHALL count 0..UPD_PERIOD-1 in ACTIVE and wrap; the wrap cycle marks every pending type due.
REQ-027 Type t SHALL also become due when hdr_acc[t] >= HDR_THR.
REQ-028 Types with both capacities 0 (infinite) SHALL never become pending or due.
REQ-029 Among due types, selection SHALL be round-robin starting after the last-served type; the selected type is latched and presented as UpdateFC one cycle after it becomes due.
REQ-030 The UpdateFC SHALL carry the alloc values sampled at latch time; on acceptance, pending, due and hdr_acc for that type SHALL clear unless a release for the same type occurs in the acceptance cycle, in which case pending is set and hdr_acc takes the new release amount.
REQ-031 Only one DLLP SHALL be outstanding at a time; the next selection starts the cycle after acceptance.
REQ-032 link_up_i falling mid-handshake SHALL drop dllp_valid_o the next cycle, with no transfer counted.

Reset
REQ-033 On rst=1, SHALL enter IDLE and clear all counters, pending, due, hdr_acc, timer and RR pointer, and drive all outputs to 0.
REQ-034 Reset SHALL take precedence over link_up_i and release inputs in the same cycle.

Structure
REQ-035 Shared package fc_pkg SHALL hold the credit-type enum (MWR, MRD, CPL), the FSM state enum and the default width constants.
REQ-036 SHALL instantiate one sub-module fc_rr_arbiter (NUM_TYPES request bits -> one-hot grant, rotating priority).

Verification
REQ-037 Reset with link_up_i=1 and caps hdr={8,8,8}, data={64,0,32}, ready=1 -> InitFC types 0,1,2 carrying (8,64), (8,0), (8,32), then init_done_o=1.
REQ-038 ready held 0 for 5 cycles during InitFC type 1 -> outputs stable for 5 cycles; one transfer only.
REQ-039 ACTIVE, release MWr hdr=1, data=4 once -> UpdateFC type 0 (9,68) at timer wrap (<=256 cycles), not earlier.
REQ-040 MWr hdr cap 254, releases of hdr=2 x2 -> threshold UpdateFC with hdr=2 (wrapped), before timer wrap.
REQ-041 All three types due simultaneously, last served=0 -> order 1,2,0.
REQ-042 link_up_i dropped during ACTIVE with pending updates -> IDLE next cycle, dllp_valid_o=0; re-raise -> full InitFC sequence.
